// File: rtl/regs_scoreboard.sv
// Register-file write-hazard scoreboard: counts in-flight GPR writes from ID issue
// to WB retirement and stalls ID on any read-after-write hazard.
module regs_scoreboard #(
  parameter int NUM_REGS = 32,
  parameter int ADDR_W   = 5,
  parameter int CNT_W    = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                id_issue_valid_i,
  input  logic                id_re1_i,
  input  logic [ADDR_W-1:0]   id_raddr1_i,
  input  logic                id_re2_i,
  input  logic [ADDR_W-1:0]   id_raddr2_i,
  input  logic                id_we_i,
  input  logic [ADDR_W-1:0]   id_waddr_i,
  input  logic                wb_retire_i,
  input  logic [ADDR_W-1:0]   wb_waddr_i,
  input  logic                flush_i,
  output logic                id_ready_o,
  output logic                stall_o,
  output logic                busy_o,
  output logic [ADDR_W+CNT_W-1:0] inflight_o,
  output logic                err_o
);

  localparam int INF_W = ADDR_W + CNT_W;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] cnt [NUM_REGS];
  logic [INF_W-1:0] inflight;
  logic             err;

  logic [CNT_W-1:0] cnt_r1, cnt_r2, cnt_iw, cnt_rw;
  logic issue_fire, retire_fire, same_reg;
  logic issue_inc, retire_dec, overflow, underflow;

  // Handshake: id_ready_o is the ready half of ID issue; an instruction transfers
  // on a cycle where id_issue_valid_i && id_ready_o. Valid never depends on ready.
  always_comb begin
    cnt_r1 = (id_raddr1_i == '0) ? '0 : cnt[id_raddr1_i];
    cnt_r2 = (id_raddr2_i == '0) ? '0 : cnt[id_raddr2_i];
    cnt_iw = cnt[id_waddr_i];
    cnt_rw = cnt[wb_waddr_i];

    stall_o = (id_re1_i && cnt_r1 != '0) || (id_re2_i && cnt_r2 != '0);

    issue_fire  = id_issue_valid_i && !stall_o && id_we_i &&
                  (id_waddr_i != '0) && !flush_i;
    retire_fire = wb_retire_i && (wb_waddr_i != '0) && !flush_i;
    same_reg    = issue_fire && retire_fire && (id_waddr_i == wb_waddr_i);

    // Matching issue/retire on one register cancel, so they can never error.
    issue_inc  = issue_fire  && !same_reg && (cnt_iw != CNT_MAX);
    overflow   = issue_fire  && !same_reg && (cnt_iw == CNT_MAX);
    retire_dec = retire_fire && !same_reg && (cnt_rw != '0);
    underflow  = retire_fire && !same_reg && (cnt_rw == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NUM_REGS; r++) cnt[r] <= '0;
      inflight <= '0;
      err      <= 1'b0;
    end else begin
      if (flush_i) begin
        for (int r = 1; r < NUM_REGS; r++) cnt[r] <= '0;
        inflight <= '0;
      end else begin
        for (int r = 1; r < NUM_REGS; r++) begin
          if (issue_inc && id_waddr_i == ADDR_W'(r))
            cnt[r] <= cnt[r] + CNT_W'(1);
          else if (retire_dec && wb_waddr_i == ADDR_W'(r))
            cnt[r] <= cnt[r] - CNT_W'(1);
        end
        case ({issue_inc, retire_dec})
          2'b10:   inflight <= inflight + INF_W'(1);
          2'b01:   inflight <= inflight - INF_W'(1);
          default: inflight <= inflight;
        endcase
      end
      if (overflow || underflow) err <= 1'b1;
    end
  end

  assign id_ready_o = !stall_o;
  assign busy_o     = (inflight != '0);
  assign inflight_o = inflight;
  assign err_o      = err;

endmodule

// File: tb/tb_regs_scoreboard.sv
// Directed bench for regs_scoreboard: expected output vectors are queued with each
// stimulus step and popped for comparison once the step is applied.
module tb_regs_scoreboard;
  localparam int ADDR_W = 5;
  localparam int CNT_W  = 2;
  localparam int INF_W  = ADDR_W + CNT_W;
  localparam int W      = 4 + INF_W;

  logic clk, rst_n;
  logic id_issue_valid_i, id_re1_i, id_re2_i, id_we_i, wb_retire_i, flush_i;
  logic [ADDR_W-1:0] id_raddr1_i, id_raddr2_i, id_waddr_i, wb_waddr_i;
  logic id_ready_o, stall_o, busy_o, err_o;
  logic [INF_W-1:0] inflight_o;

  logic [W-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  regs_scoreboard #(.NUM_REGS(32), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_issue_valid_i(id_issue_valid_i),
    .id_re1_i(id_re1_i), .id_raddr1_i(id_raddr1_i),
    .id_re2_i(id_re2_i), .id_raddr2_i(id_raddr2_i),
    .id_we_i(id_we_i), .id_waddr_i(id_waddr_i),
    .wb_retire_i(wb_retire_i), .wb_waddr_i(wb_waddr_i),
    .flush_i(flush_i),
    .id_ready_o(id_ready_o), .stall_o(stall_o), .busy_o(busy_o),
    .inflight_o(inflight_o), .err_o(err_o)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // driver tasks
  task automatic idle();
    id_issue_valid_i = 0; id_re1_i = 0; id_re2_i = 0; id_we_i = 0;
    wb_retire_i = 0; flush_i = 0;
    id_raddr1_i = '0; id_raddr2_i = '0; id_waddr_i = '0; wb_waddr_i = '0;
  endtask

  task automatic issue(input logic [ADDR_W-1:0] a);
    id_issue_valid_i = 1; id_we_i = 1; id_waddr_i = a;
  endtask

  task automatic retire(input logic [ADDR_W-1:0] a);
    wb_retire_i = 1; wb_waddr_i = a;
  endtask

  task automatic read1(input logic [ADDR_W-1:0] a);
    id_re1_i = 1; id_raddr1_i = a;
  endtask

  task automatic read2(input logic [ADDR_W-1:0] a);
    id_re2_i = 1; id_raddr2_i = a;
  endtask

  task automatic expect_out(input logic s, input logic b, input int inf, input logic e);
    exp_q.push_back({~s, s, b, INF_W'(inf), e});
  endtask

  // scoreboard: compare current outputs against the oldest expectation, then clock
  task automatic cyc(input string tag);
    logic [W-1:0] exp_v, obs_v;
    #1;
    obs_v = {id_ready_o, stall_o, busy_o, inflight_o, err_o};
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s expectation queue empty, observed %h", tag, obs_v);
    end else begin
      exp_v = exp_q.pop_front();
      checks++;
      assert (obs_v === exp_v) else begin
        errors++;
        $error("FAIL %s observed {rdy,stall,busy,infl,err}=%b expected %b", tag, obs_v, exp_v);
      end
    end
    @(posedge clk);
    #1;
    idle();
  endtask

  initial begin
    idle();
    rst_n = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1;

    expect_out(0, 0, 0, 0);                    cyc("reset_idle");

    // RAW on r5, release one cycle after retire
    issue(5);            expect_out(0, 0, 0, 0); cyc("issue_r5");
    read1(5); issue(8);  expect_out(1, 1, 1, 0); cyc("stall_r5_c1");
    read1(5); issue(8);  expect_out(1, 1, 1, 0); cyc("stall_r5_c2");
    read1(5); issue(8); retire(5);
                         expect_out(1, 1, 1, 0); cyc("stall_r5_retire_cycle");
    read1(5); issue(8);  expect_out(0, 0, 0, 0); cyc("release_r5_issue_r8");
    read2(8);            expect_out(1, 1, 1, 0); cyc("stall_r8_src2");
    retire(8);           expect_out(0, 1, 1, 0); cyc("retire_r8");
                         expect_out(0, 0, 0, 0); cyc("idle_after_r8");

    // r0 never tracked; disabled source ignored
    issue(0);            expect_out(0, 0, 0, 0); cyc("issue_r0");
    read1(0); issue(7);  expect_out(0, 0, 0, 0); cyc("read_r0_issue_r7");
    id_raddr2_i = 7;     expect_out(0, 1, 1, 0); cyc("r7_re2_disabled");
    read2(7);            expect_out(1, 1, 1, 0); cyc("r7_re2_enabled");

    // same-cycle issue/retire on r3 with cnt=1
    issue(3);            expect_out(0, 1, 1, 0); cyc("issue_r3");
    issue(3); retire(3); expect_out(0, 1, 2, 0); cyc("issue_retire_r3");
    read1(3);            expect_out(1, 1, 2, 0); cyc("r3_still_pending");
    retire(3);           expect_out(0, 1, 2, 0); cyc("retire_r3");
    read1(3); retire(7); expect_out(0, 1, 1, 0); cyc("r3_clear_retire_r7");
                         expect_out(0, 0, 0, 0); cyc("drained");

    // zero-count issue/retire on one register: no error
    issue(13); retire(13); expect_out(0, 0, 0, 0); cyc("issue_retire_r13_cnt0");
    read1(13);           expect_out(0, 0, 0, 0); cyc("r13_no_err");

    // overflow on r9
    for (int i = 0; i < 4; i++) begin
      issue(9); expect_out(0, (i != 0), i, 0); cyc($sformatf("issue_r9_%0d", i));
    end
    read1(9);            expect_out(1, 1, 3, 1); cyc("r9_saturated_err");
    retire(12);          expect_out(0, 1, 3, 1); cyc("retire_r12_underflow");
                         expect_out(0, 1, 3, 1); cyc("after_underflow");

    // flush with concurrent retire and blocked issue
    issue(4);            expect_out(0, 1, 3, 1); cyc("issue_r4");
    issue(6);            expect_out(0, 1, 4, 1); cyc("issue_r6");
    flush_i = 1; retire(4); issue(10);
                         expect_out(0, 1, 5, 1); cyc("flush_cycle");
    read1(4); read2(6);  expect_out(0, 0, 0, 1); cyc("after_flush");

    // fresh underflow after reset, then async reset mid-cycle
    rst_n = 0; #1 rst_n = 1;
                         expect_out(0, 0, 0, 0); cyc("reset_clears_err");
    retire(12);          expect_out(0, 0, 0, 0); cyc("underflow_r12");
    issue(11);           expect_out(0, 0, 0, 1); cyc("underflow_err_set");
    read1(11);
    #2 rst_n = 0;
                         expect_out(0, 0, 0, 0); cyc("async_reset_mid_cycle");
    rst_n = 1;
                         expect_out(0, 0, 0, 0); cyc("post_async_reset");

    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL leftover_expectations observed %0d expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout observed running expected finished");
    $fatal(1, "timeout");
  end
endmodule
